// File: rtl/ex_mem_reg_if.sv
// EX/MEM pipeline register bus: EX-side inputs, EX/MEM contents and hazard outputs.
interface ex_mem_reg_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned REGW = 5
);
    // EX stage instruction
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [REGW-1:0] in_rd;
    logic            in_regwrite;
    logic            in_memread;
    logic            in_memwrite;
    logic            in_unsigned;
    logic [1:0]      in_msize;
    logic [XLEN-1:0] in_store_data;

    // ALU handshake
    logic [XLEN-1:0] alu_result;
    logic            alu_bubble;
    logic            alu_valid;

    // Pipeline control
    logic            flush;
    logic            mem_stall;
    logic            ex_stall;

    // EX/MEM register contents
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_result;
    logic [REGW-1:0] out_rd;
    logic            out_regwrite;
    logic            out_memread;
    logic            out_memwrite;
    logic [1:0]      out_msize;
    logic            out_unsigned;
    logic [XLEN-1:0] out_store_data;

    // Decode-side forwarding and hazard
    logic            fwd_valid;
    logic [REGW-1:0] fwd_rd;
    logic            load_hazard;

    // Surrounding pipeline view
    modport master (
        output in_valid, in_pc, in_rd, in_regwrite, in_memread, in_memwrite, in_unsigned,
               in_msize, in_store_data, alu_result, alu_bubble, flush, mem_stall,
        input  alu_valid, ex_stall, out_valid, out_pc, out_result, out_rd, out_regwrite,
               out_memread, out_memwrite, out_msize, out_unsigned, out_store_data,
               fwd_valid, fwd_rd, load_hazard
    );

    // Pipeline register view
    modport slave (
        input  in_valid, in_pc, in_rd, in_regwrite, in_memread, in_memwrite, in_unsigned,
               in_msize, in_store_data, alu_result, alu_bubble, flush, mem_stall,
        output alu_valid, ex_stall, out_valid, out_pc, out_result, out_rd, out_regwrite,
               out_memread, out_memwrite, out_msize, out_unsigned, out_store_data,
               fwd_valid, fwd_rd, load_hazard
    );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a one-entry hold slot that parks a finished ALU
// result during MEM stalls, plus EX/MEM forwarding and load-use hazard outputs.
module ex_mem_reg #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned REGW = 5
) (
    input logic          clk,
    input logic          reset,
    ex_mem_reg_if.slave  bus
);

    typedef enum logic {StEmpty, StHeld} state_t;

    state_t          state_q;
    logic [XLEN-1:0] hold_q;

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] result_q;
    logic [REGW-1:0] rd_q;
    logic            regwrite_q;
    logic            memread_q;
    logic            memwrite_q;
    logic [1:0]      msize_q;
    logic            unsigned_q;
    logic [XLEN-1:0] store_data_q;

    logic            live;
    logic            held;
    logic            ready;
    logic [XLEN-1:0] eff_result;

    // Effective result/ready: a parked result wins over the live ALU output
    always_comb begin
        live       = bus.in_valid & ~bus.flush;
        held       = (state_q == StHeld);
        ready      = held | ~bus.alu_bubble;
        eff_result = held ? hold_q : bus.alu_result;
    end

    // Hold-slot FSM: park a finished result while MEM stalls; release on advance or flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            hold_q  <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (live && !bus.alu_bubble && bus.mem_stall) begin
                        state_q <= StHeld;
                        hold_q  <= bus.alu_result;
                    end
                end
                StHeld: begin
                    if (!bus.mem_stall || bus.flush) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    // EX/MEM register: advance only when MEM accepts; insert a bubble if EX has nothing ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            result_q     <= '0;
            rd_q         <= '0;
            regwrite_q   <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            msize_q      <= '0;
            unsigned_q   <= 1'b0;
            store_data_q <= '0;
        end else if (!bus.mem_stall) begin
            if (live && ready) begin
                valid_q      <= 1'b1;
                pc_q         <= bus.in_pc;
                result_q     <= eff_result;
                rd_q         <= bus.in_rd;
                regwrite_q   <= bus.in_regwrite;
                memread_q    <= bus.in_memread;
                memwrite_q   <= bus.in_memwrite;
                msize_q      <= bus.in_msize;
                unsigned_q   <= bus.in_unsigned;
                store_data_q <= bus.in_store_data;
            end else begin
                // Other fields keep stale values; out_valid qualifies them
                valid_q <= 1'b0;
            end
        end
    end

    // ALU is not re-qualified once its result is parked, so no multi-cycle op restarts
    assign bus.alu_valid = live & ~held;
    assign bus.ex_stall  = live & (~ready | bus.mem_stall);

    assign bus.out_valid      = valid_q;
    assign bus.out_pc         = pc_q;
    assign bus.out_result     = result_q;
    assign bus.out_rd         = rd_q;
    assign bus.out_regwrite   = regwrite_q;
    assign bus.out_memread    = memread_q;
    assign bus.out_memwrite   = memwrite_q;
    assign bus.out_msize      = msize_q;
    assign bus.out_unsigned   = unsigned_q;
    assign bus.out_store_data = store_data_q;

    // Loads cannot forward from EX/MEM; they raise the load-use hazard instead
    assign bus.fwd_valid   = valid_q & regwrite_q & ~memread_q & (rd_q != '0);
    assign bus.fwd_rd      = rd_q;
    assign bus.load_hazard = valid_q & memread_q & regwrite_q & (rd_q != '0);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: stimulus pushes expected EX/MEM transactions,
// a monitor pops and compares each time a new instruction appears on out_*.
module tb_ex_mem_reg;

    logic clk;
    logic reset;

    ex_mem_reg_if #(.XLEN(64), .REGW(5)) bus ();

    ex_mem_reg #(.XLEN(64), .REGW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] result;
        logic [63:0] store_data;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        uns;
        logic [1:0]  msize;
        logic        fwd;
        logic        lh;
    } txn_t;

    txn_t q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a new output exists after any edge where MEM was not stalled and out_valid=1
    always @(posedge clk) begin
        logic stalled;
        txn_t e;
        stalled = bus.mem_stall;
        #1;
        if (!reset && !stalled && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_output", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_result", bus.out_result, e.result);
                chk("out_rd", 64'(bus.out_rd), 64'(e.rd));
                chk("fwd_rd", 64'(bus.fwd_rd), 64'(e.rd));
                chk("ctrl", {bus.out_regwrite, bus.out_memread, bus.out_memwrite,
                             bus.out_unsigned, bus.out_msize},
                            {e.rw, e.mr, e.mw, e.uns, e.msize});
                chk("out_store_data", bus.out_store_data, e.store_data);
                chk("fwd_valid", 64'(bus.fwd_valid), 64'(e.fwd));
                chk("load_hazard", 64'(bus.load_hazard), 64'(e.lh));
            end
        end
    end

    task automatic apply(input txn_t v, input logic bubble);
        bus.in_valid      = 1'b1;
        bus.in_pc         = v.pc;
        bus.in_rd         = v.rd;
        bus.in_regwrite   = v.rw;
        bus.in_memread    = v.mr;
        bus.in_memwrite   = v.mw;
        bus.in_unsigned   = v.uns;
        bus.in_msize      = v.msize;
        bus.in_store_data = v.store_data;
        bus.alu_result    = v.result;
        bus.alu_bubble    = bubble;
    endtask

    function automatic txn_t mk(input logic [63:0] pc, input logic [63:0] res,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic mw, input logic uns, input logic [1:0] msize,
                                input logic [63:0] sd, input logic fwd, input logic lh);
        txn_t t;
        t.pc = pc; t.result = res; t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw;
        t.uns = uns; t.msize = msize; t.store_data = sd; t.fwd = fwd; t.lh = lh;
        return t;
    endfunction

    task automatic check_cleared(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_pc"}, bus.out_pc, 64'd0);
        chk({tag, "_out_result"}, bus.out_result, 64'd0);
        chk({tag, "_ctrl"}, {bus.out_rd, bus.out_regwrite, bus.out_memread, bus.out_memwrite,
                             bus.out_unsigned, bus.out_msize}, 64'd0);
        chk({tag, "_store_data"}, bus.out_store_data, 64'd0);
        chk({tag, "_fwd_lh"}, {bus.fwd_valid, bus.load_hazard, bus.fwd_rd}, 64'd0);
    endtask

    // Watchdog: never hang
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t v;
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_pc         = '0;
        bus.in_rd         = '0;
        bus.in_regwrite   = 1'b0;
        bus.in_memread    = 1'b0;
        bus.in_memwrite   = 1'b0;
        bus.in_unsigned   = 1'b0;
        bus.in_msize      = '0;
        bus.in_store_data = '0;
        bus.alu_result    = '0;
        bus.alu_bubble    = 1'b0;
        bus.flush         = 1'b0;
        bus.mem_stall     = 1'b0;
        #1;
        check_cleared("reset");
        chk("reset_alu_valid", 64'(bus.alu_valid), 64'd0);
        chk("reset_ex_stall", 64'(bus.ex_stall), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD: single cycle
        @(negedge clk);
        v = mk(64'h100, 64'h5, 5'd3, 1, 0, 0, 0, 2'd3, 64'h0, 1, 0);
        apply(v, 1'b0);
        q.push_back(v);
        #1;
        chk("add_alu_valid", 64'(bus.alu_valid), 64'd1);
        chk("add_ex_stall", 64'(bus.ex_stall), 64'd0);

        // DIV: 10 bubble cycles, then result 0x7
        @(negedge clk);
        v = mk(64'h104, 64'h7, 5'd4, 1, 0, 0, 0, 2'd3, 64'h0, 1, 0);
        apply(v, 1'b1);
        bus.alu_result = 64'hBAD;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("div_ex_stall", 64'(bus.ex_stall), 64'd1);
            @(posedge clk);
            #1;
            chk("div_bubble_out_valid", 64'(bus.out_valid), 64'd0);
            @(negedge clk);
        end
        apply(v, 1'b0);
        q.push_back(v);
        #1;
        chk("div_done_ex_stall", 64'(bus.ex_stall), 64'd0);

        // MULT 0x40 completes under a 3-cycle MEM stall
        @(negedge clk);
        v = mk(64'h108, 64'h40, 5'd6, 1, 0, 0, 0, 2'd3, 64'h0, 1, 0);
        apply(v, 1'b0);
        bus.mem_stall = 1'b1;
        #1;
        chk("mult_alu_valid_first", 64'(bus.alu_valid), 64'd1);
        chk("mult_ex_stall", 64'(bus.ex_stall), 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.alu_result = 64'hDEAD;  // ALU freed: only the parked value may be delivered
            #1;
            chk("held_alu_valid", 64'(bus.alu_valid), 64'd0);
            chk("held_ex_stall", 64'(bus.ex_stall), 64'd1);
            chk("held_out_pc", bus.out_pc, 64'h104);
            chk("held_out_result", bus.out_result, 64'h7);
        end
        @(negedge clk);
        bus.mem_stall = 1'b0;
        q.push_back(v);
        #1;
        chk("release_ex_stall", 64'(bus.ex_stall), 64'd0);
        chk("release_alu_valid", 64'(bus.alu_valid), 64'd0);

        // Load rd=5: alu_valid=1 here also shows the slot returned to EMPTY
        @(negedge clk);
        v = mk(64'h10C, 64'h2000, 5'd5, 1, 1, 0, 0, 2'd3, 64'h0, 0, 1);
        apply(v, 1'b0);
        q.push_back(v);
        #1;
        chk("after_held_alu_valid", 64'(bus.alu_valid), 64'd1);

        // Load rd=0 (unsigned word)
        @(negedge clk);
        v = mk(64'h110, 64'h2008, 5'd0, 1, 1, 0, 1, 2'd2, 64'h0, 0, 0);
        apply(v, 1'b0);
        q.push_back(v);

        // Store half
        @(negedge clk);
        v = mk(64'h114, 64'h3000, 5'd0, 0, 0, 1, 0, 2'd1, 64'hABCD, 0, 0);
        apply(v, 1'b0);
        q.push_back(v);

        // Flush during DIV
        @(negedge clk);
        v = mk(64'h118, 64'h0, 5'd7, 1, 0, 0, 0, 2'd3, 64'h0, 1, 0);
        apply(v, 1'b1);
        bus.flush = 1'b1;
        #1;
        chk("flush_alu_valid", 64'(bus.alu_valid), 64'd0);
        chk("flush_ex_stall", 64'(bus.ex_stall), 64'd0);
        @(posedge clk);
        #1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);

        // ADD, then flush together with mem_stall must leave EX/MEM untouched
        @(negedge clk);
        bus.flush = 1'b0;
        v = mk(64'h11C, 64'h99, 5'd8, 1, 0, 0, 0, 2'd3, 64'h0, 1, 0);
        apply(v, 1'b0);
        q.push_back(v);
        @(negedge clk);
        v = mk(64'h1F0, 64'h55, 5'd9, 1, 0, 0, 0, 2'd3, 64'h0, 1, 0);
        apply(v, 1'b0);
        bus.flush     = 1'b1;
        bus.mem_stall = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_stall_out_valid", 64'(bus.out_valid), 64'd1);
        chk("flush_stall_out_pc", bus.out_pc, 64'h11C);
        chk("flush_stall_out_result", bus.out_result, 64'h99);
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.mem_stall = 1'b0;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);

        // Async reset mid-cycle while HELD
        @(negedge clk);
        v = mk(64'h120, 64'h11, 5'd9, 1, 0, 0, 0, 2'd3, 64'h0, 1, 0);
        apply(v, 1'b0);
        q.push_back(v);
        @(negedge clk);
        v = mk(64'h124, 64'h22, 5'd10, 1, 0, 0, 0, 2'd3, 64'h0, 1, 0);
        apply(v, 1'b0);
        bus.mem_stall = 1'b1;
        @(negedge clk);
        #1;
        chk("pre_reset_alu_valid", 64'(bus.alu_valid), 64'd0);
        chk("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check_cleared("async_reset");
        chk("async_reset_alu_valid_empty", 64'(bus.alu_valid), 64'd1);
        bus.in_valid = 1'b0;
        #1;
        chk("async_reset_alu_valid_idle", 64'(bus.alu_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        bus.mem_stall = 1'b0;
        v = mk(64'h128, 64'h33, 5'd11, 1, 0, 0, 0, 2'd3, 64'h0, 1, 0);
        apply(v, 1'b0);
        q.push_back(v);
        #1;
        chk("post_reset_alu_valid", 64'(bus.alu_valid), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register of the five-stage core. It sits directly downstream of the execute-stage ALU. It captures the ALU result and the memory/writeback control of the instruction in EX, and holds that instruction through multi-cycle MULT/DIV bubbles and MEM-stage stalls. A one-entry hold slot frees the ALU's multi-cycle unit as soon as its result is ready. The block also produces the EX/MEM forwarding and load-use hazard signals consumed by decode.

## Interface
Parameters:
- XLEN, 64, datapath width
- REGW, 5, register-index width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  EX holds a live instruction
- in_pc  in  XLEN  PC of EX instruction
- in_rd  in  REGW  destination register
- in_regwrite, in_memread, in_memwrite, in_unsigned  in  1 each  control bits
- in_msize  in  2  access size (0=B,1=H,2=W,3=D)
- in_store_data  in  XLEN  forwarded rs2 value
- alu_result  in  XLEN  ALU output (already sign-extended for 32-bit ops)
- alu_bubble  in  1  ALU result not yet ready
- alu_valid  out  1  start/hold qualifier to the ALU's multi-cycle units
- flush  in  1  kill the instruction currently in EX
- mem_stall  in  1  MEM stage cannot accept this cycle
- ex_stall  out  1  hold ID/EX and earlier stages
- out_valid, out_pc, out_result, out_rd, out_regwrite, out_memread, out_memwrite, out_msize, out_unsigned, out_store_data  out  —  registered EX/MEM contents, widths as inputs
- fwd_valid  out  1  out_result forwardable to decode
- fwd_rd  out  REGW  equals out_rd
- load_hazard  out  1  load in EX/MEM targets a nonzero rd

## Operation
- Hold-slot FSM, states EMPTY and HELD; reset state EMPTY.
  - EMPTY→HELD: in_valid & ~flush & ~alu_bubble & mem_stall. The hold register captures alu_result.
  - HELD→EMPTY: ~mem_stall, which advances the instruction, or flush.
- Effective result: the hold register when HELD, else alu_result. Effective ready: HELD or ~alu_bubble.
- alu_valid = in_valid & ~flush & (state==EMPTY). The ALU sees valid low once the result is parked, so no multi-cycle op restarts.
- ex_stall = in_valid & ~flush & (~ready | mem_stall).
- Output register update occurs only when ~mem_stall:
  - in_valid & ~flush & ready: load all in_* fields and the effective result; out_valid=1.
  - otherwise: out_valid=0 (bubble). Other fields may retain stale values and are qualified by out_valid.
- When mem_stall=1, output registers hold unchanged, regardless of flush.
- flush kills the EX instruction only. It never clears an instruction already in EX/MEM.
- Forwarding and hazard signals:
  - fwd_valid = out_valid & out_regwrite & ~out_memread & (out_rd≠0)
  - load_hazard = out_valid & out_memread & out_regwrite & (out_rd≠0)
- Results pass through unmodified. The block performs no width or sign manipulation.

## Timing
- Reset (asynchronous): out_valid=0, all out_* fields=0, state=EMPTY, hold register=0. Derived outputs therefore reset to 0: fwd_valid, load_hazard, fwd_rd=0.
- Latency: a single-cycle ALU op in EX at cycle N appears on out_* after edge N+1.
- Multi-cycle op: ex_stall=1 while alu_bubble=1. The instruction enters EX/MEM on the edge after the first cycle alu_bubble=0, and bubbles are inserted meanwhile.
- A stall of k cycles at completion: the result is parked on the first edge and delivered the edge after mem_stall drops. alu_valid stays 0 during HELD.
- Simultaneous flush and alu completion: the instruction is dropped, the state goes to EMPTY, and no capture occurs.
- Simultaneous flush and HELD: the hold slot is discarded and the state goes to EMPTY.
- Reset asserted mid multi-cycle op: immediate clear, and alu_valid=0 combinationally once in_valid is low.
- The block has no internal back-pressure beyond one held result. in_* must stay stable while ex_stall=1.

## Test plan
- ADD result 0x5, rd=3, regwrite=1: one cycle later out_valid=1, out_result=0x5, fwd_valid=1, fwd_rd=3.
- DIV with alu_bubble high for 10 cycles, result 0x7: ex_stall=1 for those 10 cycles and out_valid=0 throughout. The edge after alu_bubble falls gives out_valid=1, out_result=0x7.
- MULT completes (result 0x40) while mem_stall=1 for 3 cycles:
  - state goes HELD and alu_valid=0;
  - out_* stay at the prior instruction;
  - the edge after mem_stall falls gives out_result=0x40 and state EMPTY.
- Load with rd=5 (memread=1, regwrite=1): load_hazard=1, fwd_valid=0. With rd=0: load_hazard=0.
- flush during an in-progress DIV (alu_bubble=1): alu_valid=0 that cycle and the next edge gives out_valid=0. With flush and mem_stall both high, EX/MEM contents are unchanged.
- Asynchronous reset pulse between clock edges while state is HELD: all outputs are 0 immediately, and after release state is EMPTY.
